// File: rtl/touch_adc_reader.sv
// touch_adc_reader: SPI master for an XPT2046-class resistive touch ADC.
// Debounces pen-down, converts X then Y, emits a validated 10-bit pair.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   enable              allow new frames (a frame in flight always completes)
//   pen_irq_n           async pen interrupt, active low
//   spi_miso            ADC data out
//   spi_sclk/cs_n/mosi  SPI mode 0 master outputs
//   sensor_x/sensor_y   last valid coordinates
//   sensor_data_ready   1-cycle strobe, coincident with new sensor_x/y
//   busy                high outside IDLE and DEBOUNCE
module touch_adc_reader #(
  parameter int CLK_DIV       = 8,
  parameter int PEN_DEBOUNCE  = 4,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pen_irq_n,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic [9:0] sensor_x,
  output logic [9:0] sensor_y,
  output logic       sensor_data_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, XFER_X, GAP,
    XFER_Y, SETTLE, CHECK, HOLDOFF
  } state_t;

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(PEN_DEBOUNCE + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(PEN_DEBOUNCE - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

  state_t state, state_d;

  logic          pen_m, pen_s;
  logic [DW-1:0] div_cnt;
  logic [5:0]    half_cnt;
  logic [BW-1:0] deb_cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    cmd_sr;
  // 16 bits are shifted in; the leading ADC busy bit falls off the top.
  logic [14:0]   rx;
  logic [9:0]    x_raw;

  logic xfer, div_end, half_end, rise, fall, last_fall;
  logic deb_done, tmr_done, go;
  logic enter_x, enter_y;

  assign xfer      = (state == XFER_X) || (state == XFER_Y);
  assign div_end   = (div_cnt == DIV_LAST);
  assign half_end  = xfer && div_end;
  assign rise      = half_end && !spi_sclk;
  assign fall      = half_end && spi_sclk;
  assign last_fall = fall && (half_cnt == 6'd47);
  assign deb_done  = (deb_cnt == DEB_LAST);
  assign tmr_done  = (tmr == TMR_LAST);
  assign go        = enable && !pen_s;
  assign enter_x   = (state_d == XFER_X) && (state != XFER_X);
  assign enter_y   = (state_d == XFER_Y) && (state != XFER_Y);
  assign spi_mosi  = cmd_sr[7];

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (go) state_d = DEBOUNCE;
      DEBOUNCE: begin
        if (pen_s)         state_d = IDLE;
        else if (deb_done) state_d = XFER_X;
      end
      XFER_X:   if (last_fall) state_d = GAP;
      GAP:      if (div_end) state_d = XFER_Y;
      XFER_Y:   if (last_fall) state_d = SETTLE;
      SETTLE:   if (div_end) state_d = CHECK;
      CHECK:    state_d = HOLDOFF;
      HOLDOFF: begin
        if (tmr_done) state_d = go ? XFER_X : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      pen_m             <= 1'b1;
      pen_s             <= 1'b1;
      div_cnt           <= '0;
      half_cnt          <= '0;
      deb_cnt           <= '0;
      tmr               <= '0;
      cmd_sr            <= '0;
      rx                <= '0;
      x_raw             <= '0;
      spi_sclk          <= 1'b0;
      spi_cs_n          <= 1'b1;
      sensor_x          <= '0;
      sensor_y          <= '0;
      sensor_data_ready <= 1'b0;
      busy              <= 1'b0;
    end else begin
      pen_m             <= pen_irq_n;
      pen_s             <= pen_m;
      state             <= state_d;
      sensor_data_ready <= 1'b0;
      busy     <= !((state_d == IDLE) ||
                    (state_d == DEBOUNCE));
      spi_cs_n <= !((state_d == XFER_X) ||
                    (state_d == XFER_Y));

      if ((state == DEBOUNCE) && !pen_s && !deb_done)
        deb_cnt <= deb_cnt + BW'(1);
      else
        deb_cnt <= '0;

      // Timer restarts on every X chip-select fall.
      if (enter_x)
        tmr <= '0;
      else if (!tmr_done)
        tmr <= tmr + TW'(1);

      if ((state_d != state) || div_end)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);

      if (state_d != state)
        half_cnt <= '0;
      else if (half_end)
        half_cnt <= half_cnt + 6'd1;

      if (rise)
        spi_sclk <= 1'b1;
      else if (fall)
        spi_sclk <= 1'b0;

      // After 8 falling edges the command has shifted out,
      // leaving zeros on mosi.
      if (enter_x)
        cmd_sr <= 8'hD0;
      else if (enter_y)
        cmd_sr <= 8'h90;
      else if (fall)
        cmd_sr <= {cmd_sr[6:0], 1'b0};

      // Rising edges 9..24 carry the 16-bit response.
      if (rise && (half_cnt >= 6'd16))
        rx <= {rx[13:0], spi_miso};

      if (last_fall && (state == XFER_X))
        x_raw <= rx[14:5];

      if ((state == CHECK) && !pen_s) begin
        sensor_x          <= x_raw;
        sensor_y          <= rx[14:5];
        sensor_data_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_touch_adc_reader.sv
// tb_touch_adc_reader: directed bench for touch_adc_reader.
// Includes a behavioural XPT2046 model and SPI/strobe monitor.
module tb_touch_adc_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pen_irq_n = 1'b1;
  logic       spi_miso = 1'b0;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic [9:0] sensor_x, sensor_y;
  logic       sensor_data_ready, busy;

  int n_tests = 0;
  int n_fail  = 0;

  touch_adc_reader #(
    .CLK_DIV(4),
    .PEN_DEBOUNCE(4),
    .SAMPLE_PERIOD(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pen_irq_n(pen_irq_n),
    .spi_miso(spi_miso),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .sensor_x(sensor_x),
    .sensor_y(sensor_y),
    .sensor_data_ready(sensor_data_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [11:0] x_val = 12'hABC;
  logic [11:0] y_val = 12'h123;
  int          cyc = 0;
  int          nfall = 0;
  int          nready = 0;
  int          rcnt = 0;
  int          fcnt = 0;
  int          lowcnt = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [7:0]  cmd_cap = '0;
  logic [15:0] stream = '0;
  logic [9:0]  rdy_x = '0;
  logic [9:0]  rdy_y = '0;
  int          fall_cyc[$];
  int          low_q[$];
  logic [7:0]  cmd_q[$];

  // ADC model + monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!spi_cs_n && prev_cs) begin
      nfall++;
      fall_cyc.push_back(cyc);
      rcnt = 0;
      fcnt = 0;
      lowcnt = 0;
    end
    if (spi_cs_n && !prev_cs)
      low_q.push_back(lowcnt);
    if (!spi_cs_n) begin
      lowcnt++;
      if (spi_sclk && !prev_sclk) begin
        rcnt++;
        if (rcnt <= 8)
          cmd_cap = {cmd_cap[6:0], spi_mosi};
      end
      if (!spi_sclk && prev_sclk) begin
        fcnt++;
        if (fcnt == 8) begin
          cmd_q.push_back(cmd_cap);
          if (cmd_cap == 8'hD0)
            stream = {1'b0, x_val, 3'b000};
          else if (cmd_cap == 8'h90)
            stream = {1'b0, y_val, 3'b000};
          else
            stream = 16'hFFFF;
        end
        if (fcnt >= 8 && fcnt <= 23)
          spi_miso = stream[4'(23 - fcnt)];
      end
    end
    if (sensor_data_ready) begin
      nready++;
      rdy_x = sensor_x;
      rdy_y = sensor_y;
    end
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int nf, nr, rel;
    logic bseen;

    tick(3);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_x", 32'(sensor_x), 32'd0);
    chk("rst_y", 32'(sensor_y), 32'd0);
    chk("rst_rdy", 32'(sensor_data_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(2);

    // Test 1: single frame, X=ABC, Y=123.
    enable = 1'b1;
    pen_irq_n = 1'b0;
    for (int i = 0; i < 600 && nready < 1; i++) tick(1);
    chk("t1_ready_seen", 32'(nready), 32'd1);
    chk("t1_x", 32'(rdy_x), 32'h2AF);
    chk("t1_y", 32'(rdy_y), 32'h048);
    chk("t1_cmd_n", 32'(cmd_q.size()), 32'd2);
    chk("t1_cmd_x", 32'(cmd_q[0]), 32'hD0);
    chk("t1_cmd_y", 32'(cmd_q[1]), 32'h90);
    chk("t1_low_x", 32'(low_q[0]), 32'd192);
    chk("t1_low_y", 32'(low_q[1]), 32'd192);
    chk("t1_xy_gap", 32'(fall_cyc[1] - fall_cyc[0]), 32'd196);

    // Test 4: pen held, periodic frames.
    x_val = 12'h555;
    y_val = 12'hFFF;
    for (int i = 0; i < 1000 && nfall < 3; i++) tick(1);
    chk("t4_fall3", 32'(nfall), 32'd3);
    chk("t4_period1", 32'(fall_cyc[2] - fall_cyc[0]), 32'd1000);
    for (int i = 0; i < 600 && nready < 2; i++) tick(1);
    chk("t4_ready2", 32'(nready), 32'd2);
    chk("t4_x", 32'(rdy_x), 32'h155);
    chk("t4_y", 32'(rdy_y), 32'h3FF);
    for (int i = 0; i < 1000 && nfall < 5; i++) tick(1);
    chk("t4_fall5", 32'(nfall), 32'd5);
    chk("t4_period2", 32'(fall_cyc[4] - fall_cyc[2]), 32'd1000);

    // Test 3: pen released during XFER_Y.
    for (int i = 0; i < 300 && nfall < 6; i++) tick(1);
    chk("t3_yfall", 32'(nfall), 32'd6);
    tick(20);
    pen_irq_n = 1'b1;
    for (int i = 0; i < 1200 && busy; i++) tick(1);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_no_ready", 32'(nready), 32'd2);
    chk("t3_hold_x", 32'(sensor_x), 32'h155);
    chk("t3_hold_y", 32'(sensor_y), 32'h3FF);
    chk("t3_no_cs", 32'(nfall), 32'd6);

    // Test 2: pen glitch shorter than debounce.
    tick(5);
    nf = nfall;
    nr = nready;
    bseen = 1'b0;
    pen_irq_n = 1'b0;
    tick(2);
    pen_irq_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy) bseen = 1'b1;
    end
    chk("t2_busy", 32'(bseen), 32'd0);
    chk("t2_cs", 32'(nfall), 32'(nf));
    chk("t2_ready", 32'(nready), 32'(nr));

    // Test 5: reset during the 10th SCLK of XFER_X.
    nf = nfall;
    nr = nready;
    pen_irq_n = 1'b0;
    for (int i = 0; i < 100 && nfall == nf; i++) tick(1);
    chk("t5_start", 32'(nfall), 32'(nf + 1));
    for (int i = 0; i < 200 && rcnt < 10; i++) tick(1);
    chk("t5_sclk10", 32'(rcnt), 32'd10);
    reset = 1'b1;
    #1;
    chk("t5_cs_n", 32'(spi_cs_n), 32'd1);
    chk("t5_sclk", 32'(spi_sclk), 32'd0);
    chk("t5_mosi", 32'(spi_mosi), 32'd0);
    chk("t5_x", 32'(sensor_x), 32'd0);
    chk("t5_y", 32'(sensor_y), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    tick(2);
    chk("t5_no_ready", 32'(nready), 32'(nr));
    nf = nfall;
    reset = 1'b0;
    rel = cyc;

    // Sync (2) + IDLE (1) + debounce (4) cycles to cs_n fall.
    for (int i = 0; i < 50 && nfall == nf; i++) tick(1);
    chk("t5_refall", 32'(nfall), 32'(nf + 1));
    chk("t5_deb_lat", 32'(fall_cyc[$] - rel), 32'd7);

    // Test 6: enable dropped in GAP.
    x_val = 12'h004;
    y_val = 12'h008;
    nr = nready;
    for (int i = 0; i < 300 && !spi_cs_n; i++) tick(1);
    chk("t6_gap", 32'(spi_cs_n), 32'd1);
    tick(1);
    enable = 1'b0;
    for (int i = 0; i < 400 && nready == nr; i++) tick(1);
    chk("t6_ready", 32'(nready), 32'(nr + 1));
    chk("t6_x", 32'(rdy_x), 32'h001);
    chk("t6_y", 32'(rdy_y), 32'h002);
    for (int i = 0; i < 1200 && busy; i++) tick(1);
    chk("t6_idle", 32'(busy), 32'd0);
    nf = nfall;
    bseen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick(1);
      if (busy) bseen = 1'b1;
    end
    chk("t6_no_cs", 32'(nfall), 32'(nf));
    chk("t6_stay_idle", 32'(bseen), 32'd0);
    chk("t6_ready_once", 32'(nready), 32'(nr + 1));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
